// File: rtl/mem_arbiter.sv
// mem_arbiter: grants a single-port RAM to either the instruction fetch path or the
// data path, holds the grant across RAM wait states, and returns one-cycle ihit/dhit pulses.
// Ports: CLK/RST; iREN/iaddr (instruction req); dREN/dWEN/daddr/dstore (data req);
//        ram_ready/ramload (RAM response); ramREN/ramWEN/ramaddr/ramstore (RAM request);
//        iload/dload (registered load data); ihit/dhit (completion pulses).
module mem_arbiter #(
  parameter int IMAX_WAIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        ram_ready,
  input  logic [31:0] ramload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ihit,
  output logic        dhit
);

  // Counter must hold IMAX_WAIT and is never narrower than 3 bits.
  localparam int CNT_W = ($clog2(IMAX_WAIT + 1) < 3) ? 3 : $clog2(IMAX_WAIT + 1);
  localparam logic [CNT_W-1:0] IMAX = CNT_W'(IMAX_WAIT);

  typedef enum logic [2:0] {IDLE, ISERV, DSERV, IDONE, DDONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic               wr_q, wr_d;
  logic [31:0]        ramaddr_q, ramaddr_d;
  logic [31:0]        ramstore_q, ramstore_d;
  logic [31:0]        iload_q, iload_d;
  logic [31:0]        dload_q, dload_d;

  logic d_req;
  logic i_starved;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    wr_d         = wr_q;
    ramaddr_d    = ramaddr_q;
    ramstore_d   = ramstore_q;
    iload_d      = iload_q;
    dload_d      = dload_q;

    d_req     = dREN | dWEN;
    i_starved = iREN && (starve_cnt_q == IMAX);

    case (state_q)
      IDLE: begin
        if (d_req && !i_starved) begin
          state_d    = DSERV;
          wr_d       = dWEN;      // read+write together is treated as a write
          ramaddr_d  = daddr;
          ramstore_d = dstore;
          // i_starved is false here, so an increment cannot pass IMAX.
          starve_cnt_d = iREN ? starve_cnt_q + 1'b1 : '0;
        end else if (iREN) begin
          state_d      = ISERV;
          ramaddr_d    = iaddr;
          starve_cnt_d = '0;
        end else begin
          starve_cnt_d = '0;
        end
      end
      ISERV: begin
        if (ram_ready) begin
          iload_d = ramload;
          state_d = IDONE;
        end else if (!iREN) begin
          state_d = IDLE;         // requester withdrew: abandon without a hit
        end
      end
      DSERV: begin
        if (ram_ready) begin
          if (!wr_q) dload_d = ramload;
          state_d = DDONE;
        end else if (!d_req) begin
          state_d = IDLE;
        end
      end
      // DONE states never grant, so a request still high during the hit
      // cycle is not served a second time.
      IDONE:   state_d = IDLE;
      DDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      wr_q         <= 1'b0;
      ramaddr_q    <= '0;
      ramstore_q   <= '0;
      iload_q      <= '0;
      dload_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      wr_q         <= wr_d;
      ramaddr_q    <= ramaddr_d;
      ramstore_q   <= ramstore_d;
      iload_q      <= iload_d;
      dload_q      <= dload_d;
    end
  end

  // Strobes and hits decode registered state only; no request-to-strobe path.
  assign ramREN   = (state_q == ISERV) || ((state_q == DSERV) && !wr_q);
  assign ramWEN   = (state_q == DSERV) && wr_q;
  assign ihit     = (state_q == IDONE);
  assign dhit     = (state_q == DDONE);
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign iload    = iload_q;
  assign dload    = dload_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the fetch-stage instruction read path and the memory-stage data read/write path of the pipelined core. Grants the shared RAM port to one requester at a time, holds it through variable RAM wait states, and returns data with one-cycle `ihit`/`dhit` pulses. The hazard unit consumes these pulses to advance or stall pipeline stages. Data accesses have priority, and a bounded-wait counter prevents instruction starvation.

## Interface
- `IMAX_WAIT`, 4: consecutive data grants allowed while an instruction request is pending before instruction is forced
- `CLK`  in  1  system clock, rising-edge
- `RST`  in  1  asynchronous, active-high reset
- `iREN`  in  1  instruction read request; held until `ihit`
- `iaddr`  in  32  instruction address
- `dREN`  in  1  data read request; held until `dhit`
- `dWEN`  in  1  data write request; held until `dhit`
- `daddr`  in  32  data address
- `dstore`  in  32  write data
- `ram_ready`  in  1  RAM completes the current access this cycle
- `ramload`  in  32  RAM read data, valid when `ram_ready`=1
- `ramREN`  out  1  RAM read strobe
- `ramWEN`  out  1  RAM write strobe
- `ramaddr`  out  32  RAM address
- `ramstore`  out  32  RAM write data
- `iload`  out  32  registered instruction word
- `dload`  out  32  registered data word
- `ihit`  out  1  one-cycle pulse: instruction access complete
- `dhit`  out  1  one-cycle pulse: data access complete

## Operation
- States: IDLE, ISERV, DSERV, IDONE, DDONE.
- IDLE behaviour:
  - `dREN|dWEN` with `starve_cnt` < `IMAX_WAIT` -> DSERV. Latch addr/data/kind. If `iREN`=1, increment `starve_cnt`.
  - Else `iREN` -> ISERV. Latch `iaddr` and clear `starve_cnt`.
  - Else stay in IDLE.
  - `starve_cnt` = `IMAX_WAIT` with both pending -> ISERV.
- `dREN` and `dWEN` both high: the access is a write.
- ISERV/DSERV:
  - Drive `ramaddr`, `ramREN`/`ramWEN` and `ramstore` from the latched request.
  - Hold until `ram_ready`=1.
  - On ready: capture `ramload` into `iload`/`dload`; a write leaves `dload` unchanged. Then go to IDONE/DDONE.
- Abort: in ISERV with `iREN`=0, or DSERV with `dREN`=`dWEN`=0, before `ram_ready` -> IDLE.
  - No hit and no load update.
  - A write already strobed is not undone.
- IDONE/DDONE:
  - Assert `ihit`/`dhit` for exactly this cycle and drive no RAM strobes.
  - Next state is IDLE. No grant is made in a DONE state, so a still-high request is never re-served.
- `starve_cnt`: 3 bits minimum, saturates at `IMAX_WAIT`, cleared on every instruction grant and when `iREN`=0 in IDLE.
- `ramaddr`/`ramstore` hold their last value outside service states. Only the strobes are qualified by state.

## Timing
- Reset (async, immediate): state IDLE, `starve_cnt` 0, `iload`=`dload`=0, `ramaddr`=`ramstore`=0, `ramREN`=`ramWEN`=`ihit`=`dhit`=0.
- Request seen in IDLE at cycle 0 -> service state in cycle 1 -> RAM strobes in cycle 1.
- `ram_ready` in cycle k (k≥1) -> hit pulse in cycle k+1, with load data valid from that cycle until the next capture.
- Zero-wait RAM: request-to-hit is 2 cycles, one transaction per 3 cycles.
- `ram_ready` outside ISERV/DSERV is ignored.
- `RST` asserted mid-service drops the access and the hit immediately. The first grant after release is on the first rising edge with `RST`=0.
- Strobes and `ihit`/`dhit` are driven directly from state registers, with no combinational path from requests to strobes.

## Test plan
- Reset: after `RST` pulse, outputs are all 0. `iREN`=1, `iaddr`=0x40, `ramload`=0x8C010004, ready in cycle 1 -> `ramREN` in cycle 1, `ihit` in cycle 2, `iload`=0x8C010004.
- Wait states: `dWEN`=1, `daddr`=0x100, `dstore`=0xDEADBEEF, ready in cycle 4 -> `ramWEN` in cycles 1-4, `dhit` only in cycle 5, `dload` unchanged.
- Priority: `iREN` and `dREN` rise together -> data served first, then instruction. The instruction grant comes 3 cycles after the data grant with zero-wait RAM.
- Starvation: `iREN` and `dREN` held continuously with `IMAX_WAIT`=4 -> exactly 4 `dhit` pulses, then an `ihit`, then the pattern repeats.
- Abort: `iREN` dropped in cycle 2 of ISERV before ready -> returns to IDLE, no `ihit`, `iload` unchanged. A pending `dREN` is granted on the next cycle.
- Async reset in DSERV with `ram_ready` pending -> `ramREN`=0 immediately, no `dhit`, state IDLE.
